alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and arbiter state encoding for the ALU arbiter slice.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;

  localparam logic [7:0] DIV_ZERO_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals shared between the arbiter and its environment.
interface alu_arbiter_if #(
  parameter int N_REQ = 4
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*8-1:0] req_A;
  logic [N_REQ*8-1:0] req_B;
  logic [N_REQ*4-1:0] req_sel;

  logic [7:0]         alu_A;
  logic [7:0]         alu_B;
  logic [3:0]         alu_Sel;
  logic [7:0]         alu_Out;
  logic               alu_CarryOut;

  logic               resp_valid;
  logic               resp_ready;
  logic [ID_W-1:0]    resp_id;
  logic [7:0]         resp_data;
  logic               resp_carry;
  logic               resp_err;

  // The master side is the requesters plus the ALU itself; the arbiter is the slave.
  modport master (
    output req_valid, req_A, req_B, req_sel, alu_Out, alu_CarryOut, resp_ready,
    input  req_ready, alu_A, alu_B, alu_Sel, resp_valid, resp_id, resp_data, resp_carry, resp_err
  );

  modport slave (
    input  req_valid, req_A, req_B, req_sel, alu_Out, alu_CarryOut, resp_ready,
    output req_ready, alu_A, alu_B, alu_Sel, resp_valid, resp_id, resp_data, resp_carry, resp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first asserted request at or after ptr_i.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic [PTR_W:0] pos;
  logic           found;

  // Walk the requesters starting at the pointer, wrapping at N rather than at a power of two.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (pos >= (PTR_W+1)'(N)) begin
        pos = pos - (PTR_W+1)'(N);
      end
      if (!found && req_i[pos[PTR_W-1:0]]) begin
        gnt_o[pos[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters, one operation in flight, round-robin fair,
// with divide-by-zero trapped locally instead of being sent to the ALU.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic         clock,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;

  arb_state_e       state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  logic [ID_W-1:0]  resp_id_q;
  logic [7:0]       alu_A_q;
  logic [7:0]       alu_B_q;
  logic [3:0]       alu_Sel_q;
  logic [7:0]       resp_data_q;
  logic             resp_carry_q;
  logic             resp_err_q;
  logic             dbz_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gnt_idx;
  logic [7:0]       selA;
  logic [7:0]       selB;
  logic [3:0]       selOp;
  logic             selDbz;
  logic             accept;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (ID_W)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (grant)
  );

  // Encode the one-hot winner and pull its operand lanes out of the packed buses.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = ID_W'(i);
      end
    end
    selA   = bus.req_A[{gnt_idx, 3'b000} +: 8];
    selB   = bus.req_B[{gnt_idx, 3'b000} +: 8];
    selOp  = bus.req_sel[{gnt_idx, 2'b00} +: 4];
    selDbz = (selOp == ALU_DIV) && (selB == 8'd0);
    accept = (state_q == IDLE) && (|grant);
    ptr_d  = (resp_id_q == ID_W'(N_REQ - 1)) ? '0 : resp_id_q + 1'b1;
  end

  // Ready is gated by reset so nothing appears accepted while reset is held.
  assign bus.req_ready  = ((state_q == IDLE) && !reset) ? grant : '0;
  assign bus.alu_A      = alu_A_q;
  assign bus.alu_B      = alu_B_q;
  assign bus.alu_Sel    = alu_Sel_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_carry = resp_carry_q;
  assign bus.resp_err   = resp_err_q;

  // EXEC is the first cycle the ALU sees the operands; WAIT then counts ALU_LATENCY edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      resp_id_q    <= '0;
      alu_A_q      <= '0;
      alu_B_q      <= '0;
      alu_Sel_q    <= '0;
      resp_data_q  <= '0;
      resp_carry_q <= 1'b0;
      resp_err_q   <= 1'b0;
      dbz_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            resp_id_q <= gnt_idx;
            dbz_q     <= selDbz;
            if (!selDbz) begin
              alu_A_q   <= selA;
              alu_B_q   <= selB;
              alu_Sel_q <= selOp;
            end
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (dbz_q) begin
            resp_data_q  <= DIV_ZERO_RESULT;
            resp_carry_q <= 1'b0;
            resp_err_q   <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q   <= CNT_W'(1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(ALU_LATENCY)) begin
            resp_data_q  <= bus.alu_Out;
            resp_carry_q <= bus.alu_CarryOut;
            resp_err_q   <= 1'b0;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a one-cycle registered ALU model plus hand-computed scenarios.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;

  logic [7:0] opA   [4] = '{default: '0};
  logic [7:0] opB   [4] = '{default: '0};
  logic [3:0] opSel [4] = '{default: '0};
  logic [7:0] aluOut   = '0;
  logic       aluCarry = 1'b0;

  alu_arbiter_if #(.N_REQ(4)) bus ();

  alu_arbiter #(
    .N_REQ       (4),
    .ALU_LATENCY (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.req_A        = {opA[3], opA[2], opA[1], opA[0]};
  assign bus.req_B        = {opB[3], opB[2], opB[1], opB[0]};
  assign bus.req_sel      = {opSel[3], opSel[2], opSel[1], opSel[0]};
  assign bus.alu_Out      = aluOut;
  assign bus.alu_CarryOut = aluCarry;

  // Reference ALU with one edge of latency; unused opcodes return A xor B so pass-through is visible.
  function automatic logic [8:0] aluCalc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    case (s)
      ALU_ADD: return {1'b0, a} + {1'b0, b};
      ALU_SUB: return {1'b0, a} - {1'b0, b};
      ALU_MUL: return {|p[15:8], p[7:0]};
      ALU_DIV: return (b == 8'd0) ? {1'b0, 8'hFF} : {1'b0, a / b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  always @(posedge clock) begin
    {aluCarry, aluOut} <= aluCalc(bus.alu_A, bus.alu_B, bus.alu_Sel);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setReq(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    opA[id]   = a;
    opB[id]   = b;
    opSel[id] = s;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic clrReq(input logic [1:0] id);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 4'hF;
    tick();
    assertCount++; if (bus.req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    assertCount++; if (bus.alu_A !== 8'd0) begin failCount++; $display("[TB] FAIL reset_alu_A got=%0d exp=0", bus.alu_A); end
    assertCount++; if (bus.alu_B !== 8'd0) begin failCount++; $display("[TB] FAIL reset_alu_B got=%0d exp=0", bus.alu_B); end
    assertCount++; if (bus.alu_Sel !== 4'd0) begin failCount++; $display("[TB] FAIL reset_alu_Sel got=%0d exp=0", bus.alu_Sel); end
    assertCount++; if (bus.resp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    assertCount++; if (bus.resp_id !== 2'd0) begin failCount++; $display("[TB] FAIL reset_resp_id got=%0d exp=0", bus.resp_id); end
    assertCount++; if (bus.resp_data !== 8'd0) begin failCount++; $display("[TB] FAIL reset_resp_data got=%0d exp=0", bus.resp_data); end
    assertCount++; if (bus.resp_carry !== 1'b0) begin failCount++; $display("[TB] FAIL reset_resp_carry got=%b exp=0", bus.resp_carry); end
    assertCount++; if (bus.resp_err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_resp_err got=%b exp=0", bus.resp_err); end
    bus.req_valid = 4'h0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    setReq(0, 8'd10, 8'd5, ALU_ADD);
    #1;
    assertCount++; if (bus.req_ready !== 4'b0001) begin failCount++; $display("[TB] FAIL single_grant got=%b exp=0001", bus.req_ready); end
    tick();
    clrReq(0);
    assertCount++; if (bus.req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL single_busy_ready got=%b exp=0000", bus.req_ready); end
    assertCount++; if (bus.alu_A !== 8'd10 || bus.alu_B !== 8'd5) begin failCount++; $display("[TB] FAIL single_alu_ops got=%0d,%0d exp=10,5", bus.alu_A, bus.alu_B); end
    assertCount++; if (bus.alu_Sel !== ALU_ADD) begin failCount++; $display("[TB] FAIL single_alu_sel got=%0d exp=0", bus.alu_Sel); end
    assertCount++; if (bus.resp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL single_early1 got=%b exp=0", bus.resp_valid); end
    tick();
    assertCount++; if (bus.resp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL single_early2 got=%b exp=0", bus.resp_valid); end
    tick();
    assertCount++; if (bus.resp_valid !== 1'b1) begin failCount++; $display("[TB] FAIL single_valid got=%b exp=1", bus.resp_valid); end
    assertCount++; if (bus.resp_id !== 2'd0) begin failCount++; $display("[TB] FAIL single_id got=%0d exp=0", bus.resp_id); end
    assertCount++; if (bus.resp_data !== 8'd15) begin failCount++; $display("[TB] FAIL single_data got=%0d exp=15", bus.resp_data); end
    assertCount++; if (bus.resp_carry !== 1'b0 || bus.resp_err !== 1'b0) begin failCount++; $display("[TB] FAIL single_flags got=%b%b exp=00", bus.resp_carry, bus.resp_err); end
    handshake();
    assertCount++; if (bus.resp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL single_release got=%b exp=0", bus.resp_valid); end
  endtask

  task automatic test_carry();
    setReq(1, 8'd200, 8'd100, ALU_ADD);
    #1;
    assertCount++; if (bus.req_ready !== 4'b0010) begin failCount++; $display("[TB] FAIL carry_grant got=%b exp=0010", bus.req_ready); end
    tick();
    clrReq(1);
    tick();
    tick();
    assertCount++; if (bus.resp_id !== 2'd1 || bus.resp_data !== 8'd44) begin failCount++; $display("[TB] FAIL carry_add got=id%0d/%0d exp=id1/44", bus.resp_id, bus.resp_data); end
    assertCount++; if (bus.resp_carry !== 1'b1) begin failCount++; $display("[TB] FAIL carry_flag got=%b exp=1", bus.resp_carry); end
    handshake();
    setReq(1, 8'd50, 8'd30, ALU_SUB);
    #1;
    assertCount++; if (bus.req_ready !== 4'b0010) begin failCount++; $display("[TB] FAIL sub_grant got=%b exp=0010", bus.req_ready); end
    tick();
    clrReq(1);
    tick();
    tick();
    assertCount++; if (bus.resp_data !== 8'd20 || bus.resp_carry !== 1'b0) begin failCount++; $display("[TB] FAIL sub_result got=%0d c%b exp=20 c0", bus.resp_data, bus.resp_carry); end
    handshake();
  endtask

  task automatic test_all_four();
    logic [3:0] expGnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] expId   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] expData [5] = '{8'd20, 8'd5, 8'd10, 8'd35, 8'd20};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    setReq(0, 8'd4, 8'd5, ALU_MUL);
    setReq(1, 8'd20, 8'd4, ALU_DIV);
    setReq(2, 8'd15, 8'd5, ALU_SUB);
    setReq(3, 8'd20, 8'd15, ALU_ADD);
    for (int k = 0; k < 5; k++) begin
      #1;
      assertCount++; if (bus.req_ready !== expGnt[k]) begin failCount++; $display("[TB] FAIL rr_grant%0d got=%b exp=%b", k, bus.req_ready, expGnt[k]); end
      tick();
      assertCount++; if (bus.req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL rr_busy%0d got=%b exp=0000", k, bus.req_ready); end
      tick();
      tick();
      assertCount++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== expId[k]) begin failCount++; $display("[TB] FAIL rr_id%0d got=v%b id%0d exp=v1 id%0d", k, bus.resp_valid, bus.resp_id, expId[k]); end
      assertCount++; if (bus.resp_data !== expData[k]) begin failCount++; $display("[TB] FAIL rr_data%0d got=%0d exp=%0d", k, bus.resp_data, expData[k]); end
      handshake();
    end
    bus.req_valid = 4'h0;
  endtask

  task automatic test_backpressure();
    setReq(0, 8'd1, 8'd2, ALU_ADD);
    setReq(3, 8'd7, 8'd8, ALU_ADD);
    #1;
    assertCount++; if (bus.req_ready !== 4'b1000) begin failCount++; $display("[TB] FAIL bp_grant got=%b exp=1000", bus.req_ready); end
    tick();
    clrReq(3);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      assertCount++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd3 || bus.resp_data !== 8'd15) begin failCount++; $display("[TB] FAIL bp_hold%0d got=v%b id%0d d%0d exp=v1 id3 d15", k, bus.resp_valid, bus.resp_id, bus.resp_data); end
      assertCount++; if (bus.req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL bp_ready%0d got=%b exp=0000", k, bus.req_ready); end
      tick();
    end
    handshake();
    assertCount++; if (bus.req_ready !== 4'b0001) begin failCount++; $display("[TB] FAIL bp_next_grant got=%b exp=0001", bus.req_ready); end
    tick();
    clrReq(0);
    tick();
    tick();
    assertCount++; if (bus.resp_id !== 2'd0 || bus.resp_data !== 8'd3) begin failCount++; $display("[TB] FAIL bp_next_resp got=id%0d/%0d exp=id0/3", bus.resp_id, bus.resp_data); end
    handshake();
  endtask

  task automatic test_div_zero();
    setReq(2, 8'd30, 8'd0, ALU_DIV);
    #1;
    assertCount++; if (bus.req_ready !== 4'b0100) begin failCount++; $display("[TB] FAIL dbz_grant got=%b exp=0100", bus.req_ready); end
    tick();
    clrReq(2);
    assertCount++; if (bus.resp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL dbz_early got=%b exp=0", bus.resp_valid); end
    assertCount++; if (bus.alu_A !== 8'd1 || bus.alu_B !== 8'd2 || bus.alu_Sel !== ALU_ADD) begin failCount++; $display("[TB] FAIL dbz_alu_hold got=%0d,%0d,%0d exp=1,2,0", bus.alu_A, bus.alu_B, bus.alu_Sel); end
    tick();
    assertCount++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2) begin failCount++; $display("[TB] FAIL dbz_valid got=v%b id%0d exp=v1 id2", bus.resp_valid, bus.resp_id); end
    assertCount++; if (bus.resp_data !== 8'hFF || bus.resp_carry !== 1'b0) begin failCount++; $display("[TB] FAIL dbz_data got=%h c%b exp=ff c0", bus.resp_data, bus.resp_carry); end
    assertCount++; if (bus.resp_err !== 1'b1) begin failCount++; $display("[TB] FAIL dbz_err got=%b exp=1", bus.resp_err); end
    assertCount++; if (bus.alu_A !== 8'd1 || bus.alu_B !== 8'd2) begin failCount++; $display("[TB] FAIL dbz_alu_still got=%0d,%0d exp=1,2", bus.alu_A, bus.alu_B); end
    handshake();
  endtask

  task automatic test_passthru();
    setReq(3, 8'h3C, 8'h0F, 4'hA);
    #1;
    assertCount++; if (bus.req_ready !== 4'b1000) begin failCount++; $display("[TB] FAIL pass_grant got=%b exp=1000", bus.req_ready); end
    tick();
    clrReq(3);
    assertCount++; if (bus.alu_Sel !== 4'hA || bus.alu_A !== 8'h3C) begin failCount++; $display("[TB] FAIL pass_sel got=%h/%h exp=a/3c", bus.alu_Sel, bus.alu_A); end
    tick();
    tick();
    assertCount++; if (bus.resp_data !== 8'h33 || bus.resp_err !== 1'b0) begin failCount++; $display("[TB] FAIL pass_resp got=%h e%b exp=33 e0", bus.resp_data, bus.resp_err); end
    handshake();
  endtask

  task automatic test_drop_and_wait();
    setReq(0, 8'd3, 8'd3, ALU_MUL);
    #1;
    assertCount++; if (bus.req_ready !== 4'b0001) begin failCount++; $display("[TB] FAIL drop_grant got=%b exp=0001", bus.req_ready); end
    tick();
    clrReq(0);
    setReq(1, 8'd5, 8'd5, ALU_ADD);
    setReq(2, 8'd1, 8'd1, ALU_ADD);
    #1;
    assertCount++; if (bus.req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL drop_busy got=%b exp=0000", bus.req_ready); end
    tick();
    tick();
    clrReq(1);
    assertCount++; if (bus.resp_data !== 8'd9) begin failCount++; $display("[TB] FAIL drop_mul got=%0d exp=9", bus.resp_data); end
    handshake();
    assertCount++; if (bus.req_ready !== 4'b0100) begin failCount++; $display("[TB] FAIL drop_regrant got=%b exp=0100", bus.req_ready); end
    tick();
    clrReq(2);
    tick();
    tick();
    assertCount++; if (bus.resp_id !== 2'd2 || bus.resp_data !== 8'd2) begin failCount++; $display("[TB] FAIL drop_waiter got=id%0d/%0d exp=id2/2", bus.resp_id, bus.resp_data); end
    handshake();
  endtask

  task automatic test_reset_in_wait();
    setReq(1, 8'd9, 8'd9, ALU_ADD);
    setReq(3, 8'd1, 8'd2, ALU_ADD);
    #1;
    assertCount++; if (bus.req_ready !== 4'b1000) begin failCount++; $display("[TB] FAIL rst_pre_grant got=%b exp=1000", bus.req_ready); end
    tick();
    tick();
    reset = 1'b1;
    #1;
    assertCount++; if (bus.req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL rst_ready got=%b exp=0000", bus.req_ready); end
    assertCount++; if (bus.alu_A !== 8'd0 || bus.alu_B !== 8'd0 || bus.alu_Sel !== 4'd0) begin failCount++; $display("[TB] FAIL rst_alu got=%0d,%0d,%0d exp=0,0,0", bus.alu_A, bus.alu_B, bus.alu_Sel); end
    assertCount++; if (bus.resp_valid !== 1'b0 || bus.resp_id !== 2'd0) begin failCount++; $display("[TB] FAIL rst_resp got=v%b id%0d exp=v0 id0", bus.resp_valid, bus.resp_id); end
    assertCount++; if (bus.resp_data !== 8'd0 || bus.resp_carry !== 1'b0 || bus.resp_err !== 1'b0) begin failCount++; $display("[TB] FAIL rst_fields got=%0d c%b e%b exp=0 c0 e0", bus.resp_data, bus.resp_carry, bus.resp_err); end
    tick();
    reset = 1'b0;
    #1;
    assertCount++; if (bus.req_ready !== 4'b0010) begin failCount++; $display("[TB] FAIL rst_first_grant got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'h0;
    tick();
    assertCount++; if (bus.resp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_no_stale got=%b exp=0", bus.resp_valid); end
    tick();
    assertCount++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_data !== 8'd18) begin failCount++; $display("[TB] FAIL rst_post_op got=v%b id%0d d%0d exp=v1 id1 d18", bus.resp_valid, bus.resp_id, bus.resp_data); end
    handshake();
  endtask

  initial begin
    bus.req_valid  = 4'h0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_single();
    test_carry();
    test_all_four();
    test_backpressure();
    test_div_zero();
    test_passthru();
    test_drop_and_wait();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
